// File: rtl/shift_frame_pkg.sv
// Shared definitions for the framed serial transmitter.
//   tx_state_t  : transmitter FSM states
//   LINE_*      : serial line levels for idle, start and stop bits
package shift_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/bit_tick_counter.sv
// Bit-period timer for the serial transmitter.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clear : restart the bit period (loads CLKS_PER_BIT-1)
//   tick  : high on the last cycle of each bit period
module bit_tick_counter #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_reg;

   // Counts down; wrapping back to RELOAD on the tick keeps consecutive
   // bit periods the same length even without an explicit clear.
   always_ff @(posedge clk) begin
      if (rst)
         cnt_reg <= '0;
      else if (clear || (cnt_reg == '0))
         cnt_reg <= RELOAD;
      else
         cnt_reg <= cnt_reg - 1'b1;
   end

   assign tick = (cnt_reg == '0);

endmodule

// File: rtl/shift_frame_tx.sv
// Framed serial transmitter: start bit, N data bits (LSB- or MSB-first),
// optional parity bit, stop bit; each bit held CLKS_PER_BIT clocks.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : word presented on in_data
//   in_ready   : high in IDLE, word accepted on in_valid && in_ready
//   in_data    : parallel word (sampled only on accept)
//   lsb_first  : bit order (sampled only on accept)
//   so         : serial line, idle high (registered)
//   busy       : frame in progress (registered)
//   frame_done : one-cycle pulse in the first IDLE cycle after a frame
module shift_frame_tx
   import shift_frame_pkg::*;
#(
   parameter int N            = 4,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         lsb_first,
   output logic         so,
   output logic         busy,
   output logic         frame_done
);

   localparam int BW = (N > 2) ? $clog2(N) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

   tx_state_t     state_reg, state_next;
   logic [N-1:0]  shift_reg, shift_next;
   logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
   logic          lsb_reg, lsb_next;
   logic          parity_reg, parity_next;
   logic          so_reg, so_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          accept;
   logic          tick;
   logic          tick_clear;

   // Restart the bit period whenever a new frame begins or the state moves.
   assign tick_clear = accept || (state_next != state_reg);

   bit_tick_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clear(tick_clear),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         lsb_reg     <= 1'b0;
         parity_reg  <= 1'b0;
         so_reg      <= LINE_IDLE;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         lsb_reg     <= lsb_next;
         parity_reg  <= parity_next;
         so_reg      <= so_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      lsb_next     = lsb_reg;
      parity_next  = parity_reg;
      accept       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               accept       = 1'b1;
               shift_next   = in_data;
               lsb_next     = lsb_first;
               parity_next  = (PARITY_ODD != 0) ? ~^in_data : ^in_data;
               bit_cnt_next = '0;
               state_next   = START;
            end
         end
         START: begin
            if (tick) state_next = DATA;
         end
         DATA: begin
            if (tick) begin
               shift_next = lsb_reg ? (shift_reg >> 1) : (shift_reg << 1);
               if (bit_cnt_reg == LAST_BIT) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) state_next = STOP;
         end
         STOP: begin
            if (tick) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered, so the line level is derived from where the
   // FSM is heading; it then lines up exactly with the state register.
   always_comb begin
      so_next = LINE_IDLE;
      case (state_next)
         IDLE:    so_next = LINE_IDLE;
         START:   so_next = LINE_START;
         DATA:    so_next = lsb_next ? shift_next[0] : shift_next[N-1];
         PARITY:  so_next = parity_next;
         STOP:    so_next = LINE_STOP;
         default: so_next = LINE_IDLE;
      endcase
      busy_next = (state_next != IDLE);
      done_next = (state_reg == STOP) && (state_next == IDLE);
   end

   assign in_ready   = (state_reg == IDLE);
   assign so         = so_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: doc/shift_frame_tx.md
# shift_frame_tx

Framed serial transmitter that sits directly downstream of the parallel register stage. It accepts an N-bit word over a valid/ready handshake and serialises it onto a single idle-high line as start bit, N data bits (LSB- or MSB-first), optional parity and stop bit. Each bit is held for a programmable number of clocks. It completes the parallel-to-serial path between the register bank and the off-block serial link.

## Interface
- N, 4, data word width (≥2)
- CLKS_PER_BIT, 1, clocks each serial bit is held (≥1)
- PARITY_EN, 1, 1 inserts a parity bit after the data bits
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data is presented
- in_ready  output  1  block can accept a word (high only in IDLE)
- in_data  input  N  parallel word
- lsb_first  input  1  bit order, sampled at accept
- so  output  1  serial line, idle high
- busy  output  1  frame in progress (any state other than IDLE)
- frame_done  output  1  one-cycle pulse when a frame completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - so=1, in_ready=1.
  - On in_valid&&in_ready: latch in_data into an internal shift register, latch lsb_first, compute and latch the parity bit, go to START.
- START: so=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - so = shift_reg[0] if lsb_first, else shift_reg[N-1].
  - At the end of each bit period, shift right or left respectively.
  - Bit counter runs 0..N-1. After bit N-1 go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - so = ^data for even parity; ~^data for odd parity.
  - Lasts one bit period, then go to STOP.
- STOP:
  - so=1 for one bit period.
  - Then go to IDLE and assert frame_done for exactly that transition cycle, i.e. the first IDLE cycle.
- in_data and lsb_first are ignored outside the accept cycle. Changing them mid-frame has no effect.
- in_valid while busy is not accepted. The upstream holds it until in_ready.
- Bit timer counts down from CLKS_PER_BIT-1. Its width is max(1,$clog2(CLKS_PER_BIT)).
- Bit counter width is max(1,$clog2(N)).
- Reset is synchronous and wins over everything, including mid-frame. Next state is IDLE, and the line returns high the cycle after the rst edge.

## Timing
- Reset values: so=1, in_ready=1, busy=0, frame_done=0. The shift register, counters and parity are cleared to 0.
- so, busy and frame_done are registered. in_ready is decoded from state.
- Accept at edge k puts the start bit on so from cycle k+1.
- Frame length is (N+2+PARITY_EN)*CLKS_PER_BIT cycles.
- frame_done is high in the cycle after the last stop-bit cycle, with in_ready=1 in that same cycle.
- Back-to-back frames: a word accepted in the frame_done cycle starts its start bit on the next cycle. This guarantees at least one idle-high cycle between frames.
- busy is high from the cycle after accept through the last stop-bit cycle.

## Structure
- Package shift_frame_pkg holds:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP)
  - localparams for the idle/start/stop line levels (1/0/1)
- One sub-module, bit_tick_counter:
  - parameter CLKS_PER_BIT
  - inputs clk, rst, clear; output tick, asserted on the last cycle of each bit period
  - The FSM clears it on accept and on every state change.

## Test plan
- Reset mid-frame: assert rst during DATA → next cycle so=1, busy=0, in_ready=1, no frame_done.
- N=4, CLKS_PER_BIT=1, even parity, lsb_first=1, in_data=4'b1011 → so sequence 0,1,1,0,1,1,1 over 7 cycles, then frame_done=1.
- Same word with lsb_first=0 → so sequence 0,1,0,1,1,1,1.
- CLKS_PER_BIT=3, PARITY_EN=0, in_data=4'b0000 → start bit and each data bit held 3 cycles, 18-cycle frame, stop held 3 cycles.
- in_valid held continuously with changing in_data → only one accept per frame, each frame carries the word present on its accept cycle, exactly one idle cycle between frames.
- PARITY_ODD=1, in_data=4'b1111 → parity bit 1; in_data=4'b0111 → parity bit 0.
